dense_2_sequencer: RTL and testbench

Sequencer for the second dense layer of the CNN accelerator. It walks the 8-bit dense weight ROM and the feature buffer in lockstep and applies the quantization offsets. Each product is multiply-accumulated into one accumulator per output neuron. Each finished neuron sum is presented on a valid/ready port to the requantization/argmax stage. The block sits between the flatten/feature buffer and the output stage, and is the only master of the weight ROM read port.

---
 rtl/dense_2_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_dense_2_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dense_2_sequencer.sv
// Second dense layer sequencer: streams the weight ROM and feature buffer in lockstep,
// multiply-accumulates one output neuron at a time and hands each sum out on valid/ready.
module dense_2_sequencer #(
    parameter int NUM_IN            = 169,
    parameter int NUM_OUT           = 3,
    parameter int addressWidthDense = 10,
    parameter int featAddrWidth     = 8,
    parameter int dataWidthDense    = 8,
    parameter int ACC_W             = 32,
    parameter int offset_ent        = 1,
    parameter int offset_fil        = 0,
    localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    output logic                                rom_en,
    output logic        [addressWidthDense-1:0] rom_addr,
    input  logic signed [dataWidthDense-1:0]    rom_rdata,
    output logic                                feat_en,
    output logic        [featAddrWidth-1:0]     feat_addr,
    input  logic signed [dataWidthDense-1:0]    feat_rdata,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic        [IDX_W-1:0]             out_idx,
    output logic signed [ACC_W-1:0]             out_acc
);

    localparam int EXT_W  = dataWidthDense + 2;
    localparam int PROD_W = 2 * EXT_W;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_OUT   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [featAddrWidth-1:0]     LAST_K = featAddrWidth'(NUM_IN - 1);
    localparam logic [IDX_W-1:0]             LAST_N = IDX_W'(NUM_OUT - 1);
    localparam logic [featAddrWidth-1:0]     ONE_F  = featAddrWidth'(1);
    localparam logic [addressWidthDense-1:0] ONE_A  = addressWidthDense'(1);
    localparam logic [IDX_W-1:0]             ONE_N  = IDX_W'(1);

    function automatic logic signed [EXT_W-1:0] add_offset(
        input logic signed [dataWidthDense-1:0] v,
        input int                               off
    );
        logic [EXT_W-1:0] ext;
        ext = {{2{v[dataWidthDense-1]}}, v};
        return ext + EXT_W'(off);
    endfunction

    function automatic logic signed [PROD_W-1:0] mac_term(
        input logic signed [dataWidthDense-1:0] f,
        input logic signed [dataWidthDense-1:0] w
    );
        logic signed [EXT_W-1:0]  fe;
        logic signed [EXT_W-1:0]  we;
        logic signed [PROD_W-1:0] p;
        fe = add_offset(f, offset_ent);
        we = add_offset(w, offset_fil);
        p  = fe * we;
        return p;
    endfunction

    function automatic logic signed [ACC_W-1:0] sext_acc(input logic signed [PROD_W-1:0] p);
        return {{(ACC_W - PROD_W){p[PROD_W-1]}}, p};
    endfunction

    logic [2:0]                      r_state;
    logic [IDX_W-1:0]                r_neuron;
    logic                            r_drain;
    logic                            r_busy;
    logic                            r_done;
    logic                            r_rom_en;
    logic                            r_feat_en;
    logic [addressWidthDense-1:0]    r_rom_addr;
    logic [featAddrWidth-1:0]        r_feat_addr;
    logic                            r_out_valid;
    logic [IDX_W-1:0]                r_out_idx;
    logic                            r_vld_p0;
    logic                            r_vld_p1;
    logic signed [PROD_W-1:0]        r_prod_p1;
    logic signed [ACC_W-1:0]         r_acc;
    logic                            w_hs;
    logic                            w_fetch_go;

    assign w_hs       = (r_state == S_OUT) && out_ready;
    assign w_fetch_go = ((r_state == S_IDLE) && start) || (w_hs && (r_neuron != LAST_N));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_neuron    <= '0;
            r_drain     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rom_en    <= 1'b0;
            r_feat_en   <= 1'b0;
            r_rom_addr  <= '0;
            r_feat_addr <= '0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_FETCH;
                        r_busy      <= 1'b1;
                        r_rom_en    <= 1'b1;
                        r_feat_en   <= 1'b1;
                        r_rom_addr  <= '0;
                        r_feat_addr <= '0;
                        r_neuron    <= '0;
                    end
                end
                S_FETCH: begin
                    if (r_feat_addr == LAST_K) begin
                        r_state   <= S_DRAIN;
                        r_rom_en  <= 1'b0;
                        r_feat_en <= 1'b0;
                        r_drain   <= 1'b0;
                    end else begin
                        r_rom_addr  <= r_rom_addr + ONE_A;
                        r_feat_addr <= r_feat_addr + ONE_F;
                    end
                end
                S_DRAIN: begin
                    if (r_drain) begin
                        r_state     <= S_OUT;
                        r_out_valid <= 1'b1;
                        r_out_idx   <= r_neuron;
                    end else begin
                        r_drain <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_neuron == LAST_N) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            // Weights are neuron-major, so the next neuron starts right after the last address
                            r_state     <= S_FETCH;
                            r_neuron    <= r_neuron + ONE_N;
                            r_rom_en    <= 1'b1;
                            r_feat_en   <= 1'b1;
                            r_rom_addr  <= r_rom_addr + ONE_A;
                            r_feat_addr <= '0;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Stage p0: read data is on rom_rdata/feat_rdata one cycle after the enables
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p0 <= r_rom_en;
            r_vld_p1 <= r_vld_p0;
        end
    end

    // Stage p1: offset-adjusted product
    always_ff @(posedge clk) begin
        if (r_vld_p0) begin
            r_prod_p1 <= mac_term(feat_rdata, rom_rdata);
        end
    end

    // Stage p2: accumulate, wrapping modulo 2^ACC_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_fetch_go) begin
            r_acc <= '0;
        end else if (r_vld_p1) begin
            r_acc <= r_acc + sext_acc(r_prod_p1);
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign rom_en    = r_rom_en;
    assign rom_addr  = r_rom_addr;
    assign feat_en   = r_feat_en;
    assign feat_addr = r_feat_addr;
    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign out_acc   = r_acc;

endmodule

// File: tb/tb_dense_2_sequencer.sv
// Bench for dense_2_sequencer: ROM/feature memory models, a scoreboard of neuron sums,
// constant-fill vector table plus stall, restart-ignore and mid-run reset sequences.
module tb_dense_2_sequencer;

    localparam int NI = 169, NO = 3, AW = 10, FW = 8, DW = 8, ACCW = 32;
    localparam int OFF_ENT = 1, OFF_FIL = 0;
    localparam int RUN_CYC = 3 * (NI + 3);

    logic clk = 1'b0;
    logic rst_n, start, busy, done, rom_en, feat_en, out_valid, out_ready;
    logic [AW-1:0] rom_addr;
    logic [FW-1:0] feat_addr;
    logic signed [DW-1:0] rom_rdata, feat_rdata;
    logic [1:0] out_idx;
    logic signed [ACCW-1:0] out_acc;

    always #5 clk = ~clk;

    dense_2_sequencer #(
        .NUM_IN(NI), .NUM_OUT(NO), .addressWidthDense(AW), .featAddrWidth(FW),
        .dataWidthDense(DW), .ACC_W(ACCW), .offset_ent(OFF_ENT), .offset_fil(OFF_FIL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
        .feat_en(feat_en), .feat_addr(feat_addr), .feat_rdata(feat_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_acc(out_acc)
    );

    logic signed [DW-1:0] wmem [0:NI*NO-1];
    logic signed [DW-1:0] fmem [0:NI-1];

    // Registered memories: one cycle read latency
    always @(posedge clk) begin
        if (rom_en)  rom_rdata  <= wmem[rom_addr];
        if (feat_en) feat_rdata <= fmem[feat_addr];
    end

    typedef struct {
        int idx;
        int acc;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic signed [DW-1:0] w;
        logic signed [DW-1:0] f;
        int                   exp_acc;
    } vec_t;
    vec_t tbl[6];

    int checks = 0, errors = 0;
    int cyc = 0, busy_rise = 0, fall_cyc = 0, last_gap = 0, done_cyc = 0;
    int done_cnt = 0, hs_cnt = 0, addr_ptr = 0, addr_err = 0, reads = 0;
    logic prev_busy = 1'b0, prev_valid = 1'b0;

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // One clock: scoreboard the handshake that the coming edge will take, then observe after the edge
    task automatic tick();
        exp_t e;
        if (out_valid && out_ready) begin
            hs_cnt++;
            if (sbq.size() == 0) begin
                check("sb_unexpected_output", 1, 0);
            end else begin
                e = sbq.pop_front();
                check($sformatf("n%0d_idx", e.idx), longint'(out_idx), e.idx);
                check($sformatf("n%0d_acc", e.idx), longint'(out_acc), e.acc);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (busy && !prev_busy) begin
            busy_rise = cyc;
            reads     = 0;
        end
        if (out_valid && !prev_valid) last_gap = cyc - fall_cyc;
        if (!out_valid && prev_valid) fall_cyc = cyc;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (!busy) addr_ptr = 0;
        if (rom_en) begin
            reads++;
            if (rom_addr !== AW'(addr_ptr) || feat_en !== 1'b1 || feat_addr !== FW'(addr_ptr % NI))
                addr_err++;
            addr_ptr++;
        end
        prev_busy  = busy;
        prev_valid = out_valid;
    endtask

    function automatic int model(input int n);
        int s = 0;
        for (int i = 0; i < NI; i++)
            s += (int'(fmem[i]) + OFF_ENT) * (int'(wmem[n*NI + i]) + OFF_FIL);
        return s;
    endfunction

    task automatic fill_const(input logic signed [DW-1:0] w, input logic signed [DW-1:0] f);
        for (int i = 0; i < NI*NO; i++) wmem[i] = w;
        for (int i = 0; i < NI; i++) fmem[i] = f;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < NI*NO; i++) wmem[i] = DW'($urandom_range(0, 255));
        for (int i = 0; i < NI; i++) fmem[i] = DW'($urandom_range(0, 255));
    endtask

    task automatic start_run(input string nm);
        addr_err = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({nm, "_busy_after_start"}, longint'(busy), 1);
        check({nm, "_first_rom_en"}, longint'({rom_en, feat_en}), 3);
    endtask

    task automatic finish_run(input string nm, input int budget, input bit timed);
        int d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) tick();
        check({nm, "_done_seen"}, done_cnt - d0, 1);
        if (timed) check({nm, "_done_latency"}, done_cyc - busy_rise, RUN_CYC);
        check({nm, "_busy_low_with_done"}, longint'(busy), 0);
        check({nm, "_addr_seq_errors"}, addr_err, 0);
        check({nm, "_reads"}, reads, NI*NO);
        check({nm, "_sb_left"}, sbq.size(), 0);
        tick();
        check({nm, "_done_pulse"}, longint'(done), 0);
    endtask

    initial begin
        exp_t e;
        int h0, d0, bad;
        logic signed [ACCW-1:0] held;

        tbl[0] = '{w: 8'sd0,    f: 8'sd0,    exp_acc: 0};
        tbl[1] = '{w: 8'sd1,    f: 8'sd2,    exp_acc: 507};
        tbl[2] = '{w: -8'sd128, f: 8'sd127,  exp_acc: -2768896};
        tbl[3] = '{w: 8'sd127,  f: -8'sd128, exp_acc: -2725801};
        tbl[4] = '{w: 8'sd5,    f: -8'sd3,   exp_acc: -1690};
        tbl[5] = '{w: -8'sd1,   f: -8'sd1,   exp_acc: 0};

        rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
        #1;
        check("rst_busy_done", longint'({busy, done}), 0);
        check("rst_enables", longint'({rom_en, feat_en}), 0);
        check("rst_addrs", longint'({rom_addr, feat_addr}), 0);
        check("rst_out", longint'({out_valid, out_idx}), 0);
        check("rst_acc", longint'(out_acc), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        for (int t = 0; t < 6; t++) begin
            fill_const(tbl[t].w, tbl[t].f);
            for (int n = 0; n < NO; n++) begin
                e.idx = n; e.acc = tbl[t].exp_acc;
                sbq.push_back(e);
            end
            start_run($sformatf("tbl%0d", t));
            finish_run($sformatf("tbl%0d", t), RUN_CYC + 20, 1'b1);
        end

        // Stall neuron 1 for 20 cycles with out_ready low
        fill_rand();
        for (int n = 0; n < NO; n++) begin e.idx = n; e.acc = model(n); sbq.push_back(e); end
        h0 = hs_cnt;
        start_run("stall");
        for (int i = 0; i < 400 && hs_cnt == h0; i++) tick();
        out_ready = 1'b0;
        for (int i = 0; i < 400 && !out_valid; i++) tick();
        check("stall_valid_reached", longint'(out_valid), 1);
        check("stall_idx", longint'(out_idx), 1);
        held = out_acc;
        check("stall_acc_value", longint'(held), model(1));
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid !== 1'b1 || out_idx !== 2'd1 || out_acc !== held || rom_en !== 1'b0 || feat_en !== 1'b0)
                bad++;
        end
        check("stall_unstable_cycles", bad, 0);
        out_ready = 1'b1;
        finish_run("stall", RUN_CYC + 20, 1'b0);
        check("stall_n2_valid_gap", last_gap, NI + 2);

        // Extra start mid-run is ignored, then reset during neuron 1 fetch aborts the run
        fill_rand();
        for (int n = 0; n < NO; n++) begin e.idx = n; e.acc = model(n); sbq.push_back(e); end
        h0 = hs_cnt;
        start_run("abort");
        for (int i = 0; i < 30; i++) tick();
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 400 && hs_cnt == h0; i++) tick();
        check("abort_n0_handshake", hs_cnt - h0, 1);
        for (int i = 0; i < 40; i++) tick();
        check("abort_fetching_n1", longint'({rom_en, busy}), 3);
        check("abort_addr_seq_errors", addr_err, 0);
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy_done", longint'({busy, done}), 0);
        check("abort_enables", longint'({rom_en, feat_en}), 0);
        check("abort_addrs", longint'({rom_addr, feat_addr}), 0);
        check("abort_out", longint'({out_valid, out_idx}), 0);
        check("abort_acc", longint'(out_acc), 0);
        sbq.delete();
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_idle", longint'(busy), 0);

        fill_rand();
        for (int n = 0; n < NO; n++) begin e.idx = n; e.acc = model(n); sbq.push_back(e); end
        start_run("post_reset");
        finish_run("post_reset", RUN_CYC + 20, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
